// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: N_REQ packet sources share one FIFO write port,
// each grant covering one packet or at most BURST_MAX beats.
module fifo_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [7:0]           fifo_din,
    output logic [2:0]           grant_id,
    output logic                 busy
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_MAX) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);
    localparam logic [OW-1:0] ID_LAST = OW'(N_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [OW-1:0] pick;
    logic          any_valid;
    logic [OW:0]   cand;
    logic          own_valid;
    logic          own_last;
    logic [7:0]    own_data;
    logic [CW-1:0] cnt_inc;
    logic          release_hit;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        pick      = rr_ptr_q;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (OW+1)'(k);
            if (cand >= (OW+1)'(N_REQ))
                cand = cand - (OW+1)'(N_REQ);
            if (req_valid[cand[OW-1:0]]) begin
                pick      = cand[OW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        own_data = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OW'(i))
                own_data = req_data[8*i +: 8];
        end
    end

    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];

    assign busy     = (state_q == GRANT);
    assign fifo_wr  = busy & own_valid & ~fifo_full;
    assign fifo_din = busy ? own_data : 8'h00;
    assign grant_id = 3'(owner_q);

    always_comb begin
        req_ready = '0;
        if (busy)
            req_ready[owner_q] = ~fifo_full;
    end

    assign cnt_inc     = cnt_q + 1'b1;
    assign release_hit = own_last | (cnt_inc == CNT_MAX);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (fifo_wr) begin
                    cnt_d = cnt_inc;
                    if (release_hit) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        rr_ptr_d = (owner_q == ID_LAST) ? '0 : owner_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized and directed bench for fifo_wr_arb against a cycle-level
// behavioural model of the arbitration rules.
module tb_fifo_wr_arb;

    localparam int N  = 4;
    localparam int BM = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_wr;
    logic [7:0]       fifo_din;
    logic [2:0]       grant_id;
    logic             busy;

    fifo_wr_arb #(.N_REQ(N), .BURST_MAX(BM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Packet sources: len = beats left, each accepted beat increments data.
    int         src_len   [N];
    logic [7:0] src_dat   [N];
    bit         src_single[N];
    bit         src_hold  [N];
    logic [N-1:0] acc;

    typedef struct { int c; int id; int d; } ent_t;
    ent_t log_q[$];

    // Model state
    bit m_busy;
    int m_owner, m_cnt, m_rr;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = (src_len[i] != 0) && !src_hold[i];
            req_last[i]         = (src_len[i] == 1) || src_single[i];
            req_data[8*i +: 8]  = src_dat[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                src_len[i]--;
                src_dat[i]++;
            end
        end
        drive();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load(int i, int len, logic [7:0] d, bit single = 1'b0);
        src_len[i]    = len;
        src_dat[i]    = d;
        src_single[i] = single;
        drive();
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_len[i] = 0; src_dat[i] = 8'h00; src_single[i] = 1'b0; src_hold[i] = 1'b0;
        end
        drive();
    endtask

    task automatic do_reset();
        clear_src();
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        run(2);
        rst_n = 1'b1;
        tick();
        log_q.delete();
    endtask

    task automatic chk_log(string nm, int k, int c, int id, int d);
        if (k >= log_q.size()) begin
            chk({nm, "_present"}, log_q.size(), k + 1);
        end else begin
            chk({nm, "_cycle"}, log_q[k].c, c);
            chk({nm, "_id"},    log_q[k].id, id);
            chk({nm, "_data"},  log_q[k].d, d);
        end
    endtask

    // Compare and model-advance process: inputs are stable from posedge+1
    // until the next posedge, so the negedge sees what the next edge will use.
    initial begin
        bit          e_wr;
        logic [7:0]  e_din;
        logic [N-1:0] e_rdy;
        bit          found;
        ent_t        e;
        m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_owner = 0; m_cnt = 0; m_rr = 0;
                chk("rst_busy",  int'(busy), 0);
                chk("rst_wr",    int'(fifo_wr), 0);
                chk("rst_din",   int'(fifo_din), 0);
                chk("rst_ready", int'(req_ready), 0);
                chk("rst_gid",   int'(grant_id), 0);
            end else begin
                e_wr  = m_busy && req_valid[m_owner] && !fifo_full;
                e_din = m_busy ? req_data[8*m_owner +: 8] : 8'h00;
                e_rdy = '0;
                if (m_busy) e_rdy[m_owner] = !fifo_full;
                chk("busy",      int'(busy), int'(m_busy));
                chk("fifo_wr",   int'(fifo_wr), int'(e_wr));
                chk("fifo_din",  int'(fifo_din), int'(e_din));
                chk("req_ready", int'(req_ready), int'(e_rdy));
                if (m_busy) chk("grant_id", int'(grant_id), m_owner);
                if (!m_busy) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && req_valid[(m_rr + k) % N]) begin
                            found   = 1;
                            m_owner = (m_rr + k) % N;
                        end
                    end
                    if (found) begin
                        m_busy = 1;
                        m_cnt  = 0;
                    end
                end else if (e_wr) begin
                    m_cnt++;
                    if (req_last[m_owner] || m_cnt == BM) begin
                        m_busy = 0;
                        m_rr   = (m_owner + 1) % N;
                    end
                end
            end
            if (fifo_wr) begin
                e.c = cyc; e.id = int'(grant_id); e.d = int'(fifo_din);
                log_q.push_back(e);
            end
            acc = req_valid & req_ready;
            cyc++;
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        acc       = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        clear_src();
        run(3);
        rst_n = 1'b1;
        tick();
        chk("idle_gid", int'(grant_id), 0);
        chk("idle_busy", int'(busy), 0);

        // Single requester, three-beat packet
        do_reset();
        c0 = cyc;
        load(2, 3, 8'hA1);
        run(6);
        chk("t1_count", log_q.size(), 3);
        for (int k = 0; k < 3; k++) chk_log("t1", k, c0 + 1 + k, 2, 8'hA1 + k);
        chk("t1_idle", int'(busy), 0);

        // Burst cap: 8-beat packet split into two grants with one idle cycle
        do_reset();
        c0 = cyc;
        load(0, 8, 8'h10);
        run(12);
        chk("t2_count", log_q.size(), 8);
        for (int k = 0; k < 8; k++)
            chk_log("t2", k, c0 + 1 + k + (k >= 4 ? 1 : 0), 0, 8'h10 + k);

        // Round-robin with single-beat packets
        do_reset();
        c0 = cyc;
        for (int i = 0; i < N; i++) src_single[i] = 1'b1;
        for (int i = 0; i < N; i++) load(i, 5, 8'(8'h40 + 16 * i), 1'b1);
        run(45);
        chk("t3_count", log_q.size(), 20);
        for (int k = 0; k < 5; k++)
            chk_log("t3", k, c0 + 1 + 2 * k, k % 4, 8'h40 + 16 * (k % 4) + k / 4);

        // Backpressure: five full cycles after two beats
        do_reset();
        c0 = cyc;
        load(1, 4, 8'hB0);
        run(3);
        fifo_full = 1'b1;
        run(2);
        chk("t4_gid_full",   int'(grant_id), 1);
        chk("t4_busy_full",  int'(busy), 1);
        chk("t4_ready_full", int'(req_ready[1]), 0);
        run(3);
        fifo_full = 1'b0;
        run(4);
        chk("t4_count", log_q.size(), 4);
        chk_log("t4", 0, c0 + 1, 1, 8'hB0);
        chk_log("t4", 1, c0 + 2, 1, 8'hB1);
        chk_log("t4", 2, c0 + 8, 1, 8'hB2);
        chk_log("t4", 3, c0 + 9, 1, 8'hB3);

        // Reset mid-burst, then arbitration restarts from requester 0
        do_reset();
        load(2, 4, 8'hC0);
        run(3);
        chk("t5_pre_count", log_q.size(), 2);
        rst_n = 1'b0;
        clear_src();
        #1;
        chk("t5_rst_wr",   int'(fifo_wr), 0);
        chk("t5_rst_busy", int'(busy), 0);
        run(2);
        rst_n = 1'b1;
        log_q.delete();
        c0 = cyc;
        load(3, 1, 8'hD3);
        load(0, 1, 8'hD0);
        run(6);
        chk("t5_count", log_q.size(), 2);
        chk_log("t5", 0, c0 + 1, 0, 8'hD0);
        chk_log("t5", 1, c0 + 3, 3, 8'hD3);

        // Owner stalls three cycles while requester 2 waits
        do_reset();
        c0 = cyc;
        load(0, 4, 8'hE0);
        load(2, 1, 8'hF2);
        run(2);
        src_hold[0] = 1'b1;
        drive();
        run(1);
        chk("t6_ready2", int'(req_ready[2]), 0);
        chk("t6_gid",    int'(grant_id), 0);
        chk("t6_busy",   int'(busy), 1);
        run(2);
        src_hold[0] = 1'b0;
        drive();
        run(6);
        chk("t6_count", log_q.size(), 5);
        chk_log("t6", 0, c0 + 1, 0, 8'hE0);
        chk_log("t6", 1, c0 + 5, 0, 8'hE1);
        chk_log("t6", 2, c0 + 6, 0, 8'hE2);
        chk_log("t6", 3, c0 + 7, 0, 8'hE3);
        chk_log("t6", 4, c0 + 9, 2, 8'hF2);

        // Random traffic with backpressure, stalls and occasional resets
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            tick();
            fifo_full = ($urandom % 4) == 0;
            for (int i = 0; i < N; i++) begin
                if (src_len[i] == 0 && ($urandom % 3) == 0) begin
                    src_len[i]    = 1 + int'($urandom % 6);
                    src_dat[i]    = 8'($urandom);
                    src_single[i] = ($urandom % 4) == 0;
                end
                src_hold[i] = ($urandom % 8) == 0;
            end
            if (($urandom % 700) == 0) begin
                rst_n = 1'b0;
                drive();
                tick();
                rst_n = 1'b1;
            end
            drive();
        end
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) src_hold[i] = 1'b0;
        drive();
        run(200);
        chk("drain_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter BURST_MAX, default 4, maximum beats per grant (1..16).
REQ-003 Port clk  input  1  single clock; all state on rising edge; same clock as the FIFO write side (clk1).
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port req_valid  input  N_REQ  requester i has a beat on req_data.
REQ-006 Port req_data  input  8*N_REQ  requester i data at bits [8i+7:8i].
REQ-007 Port req_last  input  N_REQ  requester i beat is final beat of its packet.
REQ-008 Port req_ready  output  N_REQ  beat of requester i accepted this cycle when valid&ready.
REQ-009 Port fifo_full  input  1  FIFO full flag.
REQ-010 Port fifo_wr  output  1  FIFO write strobe.
REQ-011 Port fifo_din  output  8  FIFO write data.
REQ-012 Port grant_id  output  3  index of current owner; meaningful only when busy=1.
REQ-013 Port busy  output  1  a requester holds the grant.

Function
REQ-014 Two states: IDLE, GRANT; state, owner, beat counter, and round-robin pointer are registers.
REQ-015 IDLE: if any req_valid=1, next edge selects owner = first i with req_valid[i]=1 searching from rr_ptr upward modulo N_REQ, enters GRANT, beat counter cleared to 0.
REQ-016 IDLE with no req_valid: remain IDLE; arbitration latency from first valid to GRANT is exactly 1 cycle.
REQ-017 GRANT: req_ready[owner] = !fifo_full, combinational; req_ready of all non-owners = 0.
REQ-018 fifo_wr = GRANT & req_valid[owner] & !fifo_full, combinational, zero latency; fifo_din = req_data[owner] slice; fifo_din = 0 when not GRANT.
REQ-019 Accepted beat = fifo_wr high at a rising edge; beat counter increments by 1 per accepted beat.
REQ-020 Grant released (GRANT -> IDLE) on the edge accepting a beat with req_last[owner]=1, or the beat making count = BURST_MAX, whichever first.
REQ-021 On release, rr_ptr = (owner+1) mod N_REQ; the next grant needs one IDLE cycle (one-cycle bubble between bursts, by design).
REQ-022 fifo_full=1 in GRANT: no write, no count change, grant held; transfer resumes in the cycle fifo_full falls.
REQ-023 Owner drops req_valid mid-burst: grant held, no write, no timeout; other requesters wait.
REQ-024 Non-owner req_valid/req_data changes never affect fifo_wr or fifo_din.
REQ-025 busy = (state==GRANT); grant_id = owner register, zero-extended to 3 bits.
REQ-026 Beat counter width = clog2(BURST_MAX)+1 bits; never wraps, since release occurs at BURST_MAX.
REQ-027 Each requester granted at most once per N_REQ consecutive grants while all requesters stay valid (fairness).

Reset
REQ-028 rst_n=0 asynchronously forces state=IDLE, owner=0, rr_ptr=0, beat counter=0.
REQ-029 During and after reset until first grant: fifo_wr=0, fifo_din=0, req_ready=0, busy=0, grant_id=0.
REQ-030 Reset asserted mid-burst aborts the burst immediately; no partial-beat write is issued in the reset cycle.
REQ-031 After rst_n deasserts, first arbitration starts from requester 0.

Verification
REQ-032 Single requester: req 2 sends 3 beats 0xA1,0xA2,0xA3 (last on 3rd), FIFO not full -> busy 1 cycle after valid, fifo_wr high 3 consecutive cycles with that data, then IDLE.
REQ-033 Burst cap: req 0 valid continuously, last never set, BURST_MAX=4 -> exactly 4 writes, 1 IDLE cycle, then req 0 regranted for the next 4.
REQ-034 Round-robin: all 4 requesters valid with single-beat packets -> grant order 0,1,2,3,0, each write separated by one IDLE cycle.
REQ-035 Backpressure: fifo_full high 5 cycles mid-burst of req 1 -> fifo_wr and req_ready[1] low for those 5 cycles, grant_id stays 1, count unchanged, burst completes after.
REQ-036 Reset mid-burst: rst_n low after 2 of 4 beats -> fifo_wr, busy low immediately; after release, req 3 and req 0 both valid -> req 0 granted first.
REQ-037 Stall: owner drops valid 3 cycles while req 2 valid -> no writes, grant held, req_ready[2]=0 throughout.
